// File: rtl/multi_array_fill_pkg.sv
// Shared types and helpers for the multi-array stream loader.
package multi_array_fill_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } STATES_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_array_fill.sv
// Fills NUM_ARRAYS arrays in turn from one header-prefixed word stream,
// driving a shared write port plus array select and per-array loaded flags.
module multi_array_fill
  import multi_array_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_SIZE  = 16,
  parameter int NUM_ARRAYS = 4,
  parameter int SEL_WIDTH  = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1,
  parameter int DATA_SIZE  = max2(WORD_SIZE, ADDR_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_SIZE-1:0]  data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  restart,
  output logic                  we,
  output logic [SEL_WIDTH-1:0]  wsel,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WORD_SIZE-1:0]  q,
  output logic [NUM_ARRAYS-1:0] loaded,
  output logic                  all_loaded,
  output logic                  err,
  output STATES_t               dbg_state
);

  localparam logic [ADDR_WIDTH:0]  DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_ARRAYS - 1);

  STATES_t               state, state_nxt;
  logic [SEL_WIDTH-1:0]  wsel_nxt;
  logic [ADDR_WIDTH-1:0] waddr_nxt;
  logic [ADDR_WIDTH:0]   len, len_nxt;
  logic [NUM_ARRAYS-1:0] loaded_nxt;
  logic                  err_nxt;
  logic                  advance;
  logic [ADDR_WIDTH:0]   hdr_len;
  logic                  last_word;

  // Handshake: a word transfers on a rising edge where data_valid && data_ready;
  // data_ready depends only on state, never on data_valid.
  assign hdr_len    = data[ADDR_WIDTH:0];
  assign last_word  = ({1'b0, waddr} == (len - 1'b1));
  assign q          = data[WORD_SIZE-1:0];
  assign all_loaded = (state == S_DONE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt  = state;
    wsel_nxt   = wsel;
    waddr_nxt  = waddr;
    len_nxt    = len;
    loaded_nxt = loaded;
    err_nxt    = err;
    advance    = 1'b0;
    data_ready = 1'b0;
    we         = 1'b0;

    case (state)
      S_RESET: state_nxt = S_HDR;

      S_HDR: begin
        data_ready = 1'b1;
        if (data_valid) begin
          len_nxt   = hdr_len;
          waddr_nxt = '0;
          if (hdr_len > DEPTH) begin
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end else if (hdr_len == '0) begin
            loaded_nxt[wsel] = 1'b1;
            advance          = 1'b1;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        data_ready = 1'b1;
        we         = data_valid;
        if (data_valid) begin
          // Last-word test comes first so waddr+1 never needs its carry.
          if (last_word) begin
            loaded_nxt[wsel] = 1'b1;
            waddr_nxt        = '0;
            advance          = 1'b1;
          end else begin
            waddr_nxt = waddr + 1'b1;
          end
        end
      end

      S_DONE, S_ERR: begin
        if (restart) begin
          loaded_nxt = '0;
          wsel_nxt   = '0;
          waddr_nxt  = '0;
          err_nxt    = 1'b0;
          state_nxt  = S_HDR;
        end
      end

      default: state_nxt = S_RESET;
    endcase

    if (advance) begin
      if (wsel == LAST_SEL) begin
        state_nxt = S_DONE;
      end else begin
        wsel_nxt  = wsel + 1'b1;
        state_nxt = S_HDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_RESET;
      wsel   <= '0;
      waddr  <= '0;
      len    <= '0;
      loaded <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      wsel   <= wsel_nxt;
      waddr  <= waddr_nxt;
      len    <= len_nxt;
      loaded <= loaded_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_multi_array_fill.sv
// Randomised bench for multi_array_fill: a stream-parsing reference model plus
// an expected-write queue, checked every cycle on the falling edge.
module tb_multi_array_fill;

  localparam int AW    = 4;
  localparam int WS    = 8;
  localparam int NA    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int EW    = 1 + AW + WS;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic          restart;
  logic          we;
  logic [0:0]    wsel;
  logic [AW-1:0] waddr;
  logic [WS-1:0] q;
  logic [NA-1:0] loaded;
  logic          all_loaded;
  logic          err;
  multi_array_fill_pkg::STATES_t dbg_state;

  multi_array_fill #(
    .ADDR_WIDTH(AW),
    .WORD_SIZE (WS),
    .NUM_ARRAYS(NA)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .restart   (restart),
    .we        (we),
    .wsel      (wsel),
    .waddr     (waddr),
    .q         (q),
    .loaded    (loaded),
    .all_loaded(all_loaded),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] stream[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: where the stream parser is, in terms of arrays and words left
  bit            m_valid  = 1'b0;
  bit            m_rst    = 1'b1;
  bit            m_done   = 1'b0;
  bit            m_err    = 1'b0;
  int            m_arr    = 0;
  int            m_len    = 0;
  int            m_rem    = 0;
  logic [NA-1:0] m_loaded = '0;

  function automatic void finish_array();
    m_loaded[m_arr] = 1'b1;
    if (m_arr == NA - 1) m_done = 1'b1;
    else m_arr++;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_valid = 1'b1; m_rst = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_arr = 0; m_rem = 0; m_loaded = '0;
    end else if (m_rst) begin
      m_rst = 1'b0;
    end else if (m_done || m_err) begin
      if (restart) begin
        m_done = 1'b0; m_err = 1'b0; m_loaded = '0; m_arr = 0; m_rem = 0;
      end
    end else if (data_valid) begin
      if (m_rem == 0) begin
        int l;
        l = int'(data[AW:0]);
        if (l > DEPTH) m_err = 1'b1;
        else if (l == 0) finish_array();
        else begin m_len = l; m_rem = l; end
      end else begin
        m_rem--;
        if (m_rem == 0) finish_array();
      end
    end
  end

  // scoreboard / compare process
  always @(negedge clk) begin : cmp
    logic          e_ready;
    logic          e_we;
    logic [EW-1:0] e;
    if (m_valid) begin
      e_ready = !m_rst && !m_done && !m_err;
      e_we    = e_ready && (m_rem != 0) && data_valid;
      chk("data_ready", 32'(data_ready), 32'(e_ready));
      chk("we", 32'(we), 32'(e_we));
      chk("loaded", 32'(loaded), 32'(m_loaded));
      chk("err", 32'(err), 32'(m_err));
      chk("all_loaded", 32'(all_loaded), 32'(m_done));
      chk("wsel", 32'(wsel), 32'(m_arr));
      chk("waddr", 32'(waddr), (m_rem == 0) ? 32'd0 : 32'(m_len - m_rem));
      if (we === 1'b1) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write_unexpected: got 0x%0h expected none at %0t", {wsel, waddr, q}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write", 32'({wsel, waddr, q}), 32'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input int len, input int upper);
    logic [DW-1:0] w;
    w = {3'(upper), 5'(len)};
    stream.push_back(w);
  endtask

  task automatic push_word(input int sel, input int addr, input logic [WS-1:0] w);
    logic [EW-1:0] e;
    e = {1'(sel), AW'(addr), w};
    stream.push_back(w);
    exp_q.push_back(e);
  endtask

  task automatic push_arr(input int sel, input int len);
    push_hdr(len, 0);
    for (int i = 0; i < len; i++) push_word(sel, i, WS'($urandom_range(0, 255)));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // gap_mode 0: valid held high, 1: valid low on alternate cycles, 2: random gaps and restarts
  task automatic send(input int gap_mode);
    int budget;
    bit toggle;
    bit gap;
    bit fired;
    budget = 0;
    toggle = 1'b0;
    while (stream.size() > 0) begin
      gap = 1'b0;
      if (gap_mode == 1) begin
        gap    = toggle;
        toggle = !toggle;
      end else if (gap_mode == 2) begin
        gap = ($urandom_range(0, 2) == 0);
      end
      restart = (gap_mode == 2) && ($urandom_range(0, 5) == 0);
      if (gap) begin
        data_valid = 1'b0;
        data       = DW'($urandom);
        tick();
      end else begin
        data_valid = 1'b1;
        data       = stream[0];
        @(negedge clk);
        fired = (data_ready === 1'b1);
        tick();
        if (fired) begin
          void'(stream.pop_front());
          budget = 0;
        end else begin
          budget++;
          if (budget > 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no data_ready expected data_ready within 20 cycles at %0t", $time);
            stream.delete();
          end
        end
      end
    end
    data_valid = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic basic_stream();
    push_hdr(3, 0);
    push_word(0, 0, 8'hA0); push_word(0, 1, 8'hA1); push_word(0, 2, 8'hA2);
    push_hdr(2, 0);
    push_word(1, 0, 8'hB0); push_word(1, 1, 8'hB1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1000000 at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; data = '0; data_valid = 1'b0; restart = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(data_ready), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_all_loaded", 32'(all_loaded), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    resetn = 1'b1;
    tick();

    // basic load
    basic_stream();
    send(0);
    chk("basic_all_loaded", 32'(all_loaded), 32'd1);
    chk("basic_loaded", 32'(loaded), 32'h3);
    chk("basic_ready_low", 32'(data_ready), 32'd0);
    chk("basic_wr_count", 32'(wr_count), 32'd5);

    // restart after done, then backpressure
    pulse_restart();
    chk("restart_loaded", 32'(loaded), 32'd0);
    chk("restart_all_loaded", 32'(all_loaded), 32'd0);
    basic_stream();
    send(1);
    chk("gaps_wr_count", 32'(wr_count), 32'd10);
    chk("gaps_all_loaded", 32'(all_loaded), 32'd1);

    // zero-length and full-depth arrays
    pulse_restart();
    push_arr(0, 0);
    push_arr(1, 16);
    send(0);
    chk("bound_loaded", 32'(loaded), 32'h3);
    chk("bound_err", 32'(err), 32'd0);
    chk("bound_waddr", 32'(waddr), 32'd0);
    chk("bound_wr_count", 32'(wr_count), 32'd26);

    // oversize header
    pulse_restart();
    push_hdr(17, 0);
    send(0);
    chk("oversize_err", 32'(err), 32'd1);
    chk("oversize_ready", 32'(data_ready), 32'd0);
    tick();
    chk("oversize_err_sticky", 32'(err), 32'd1);
    chk("oversize_loaded", 32'(loaded), 32'd0);
    pulse_restart();
    chk("oversize_clear", 32'(err), 32'd0);
    push_arr(0, 1);
    push_arr(1, 1);
    send(0);
    chk("oversize_reload", 32'(all_loaded), 32'd1);

    // reset part-way through array 0
    pulse_restart();
    push_hdr(3, 0);
    push_word(0, 0, 8'h11);
    push_word(0, 1, 8'h22);
    send(0);
    resetn = 1'b0;
    tick();
    chk("midrst_loaded", 32'(loaded), 32'd0);
    chk("midrst_wsel", 32'(wsel), 32'd0);
    chk("midrst_waddr", 32'(waddr), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    tick();
    push_arr(0, 3);
    push_arr(1, 2);
    send(0);
    chk("midrst_reload", 32'(all_loaded), 32'd1);

    // restart while filling is ignored
    pulse_restart();
    push_hdr(3, 0);
    push_word(0, 0, 8'h5A);
    send(0);
    pulse_restart();
    chk("dataRestart_waddr", 32'(waddr), 32'd1);
    chk("dataRestart_wsel", 32'(wsel), 32'd0);
    push_word(0, 1, 8'h6B);
    push_word(0, 2, 8'h7C);
    push_arr(1, 2);
    send(0);
    chk("dataRestart_done", 32'(all_loaded), 32'd1);

    pulse_restart();
    push_hdr(1, 0); push_word(0, 0, 8'hC0);
    push_hdr(1, 0); push_word(1, 0, 8'hD0);
    send(0);
    chk("cd_loaded", 32'(loaded), 32'h3);

    // randomised sequences with gaps, ignored restarts and occasional oversize headers
    for (int r = 0; r < 15; r++) begin
      pulse_restart();
      for (int a = 0; a < NA; a++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
          push_hdr($urandom_range(17, 31), $urandom_range(0, 7));
          break;
        end else if (sel == 1) begin
          push_hdr(0, $urandom_range(0, 7));
        end else begin
          push_arr(a, $urandom_range(1, 16));
        end
      end
      send(2);
      repeat (3) tick();
      chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
